// File: rtl/arch_map_table.sv
// ---------------------------------------------------------------------------
// arch_map_table
//
// Retirement-side (architectural) rename table. The ROB retires up to
// RETIRE_WIDTH instructions per cycle into this table. The physical tag that
// each retire overwrites is handed back to the free list one cycle later.
//
// On a branch recovery the committed mapping (arch_table_o, including that
// cycle's retires) is what the speculative map table copies. The block then
// runs a rebuild scan over every physical tag and reports the tags that no
// architectural entry references, so that the free list can regenerate itself.
//
// Ports
//   clk, reset          clock (rising edge); asynchronous active-high reset
//   retire_*_i          per-slot retire request from the ROB (slot 0 older)
//   retire_ready_o      ROB may retire; low while the rebuild scan runs
//   branch_recover_i    mispredicted branch retiring this cycle
//   arch_table_o        committed mapping after this cycle's retires (comb.)
//   free_valid_o/tag_o  superseded tags returned to the free list (registered)
//   rebuild_start_o     first rebuild cycle: free list clears itself
//   rebuild_valid_o/tag_o  per-lane free tags found by the scan
//   rebuild_done_o      last rebuild beat
//
// Optional build macro ARCH_MAP_DEBUG_EN adds arch_table_Debug,
// state_Debug and scan_count_Debug observation outputs.
// ---------------------------------------------------------------------------
module arch_map_table #(
    parameter int ARCHREG_NUMBER = 32,
    parameter int PREG_NUMBER    = 64,
    parameter int RETIRE_WIDTH   = 2,
    parameter int REBUILD_WIDTH  = 4,
    localparam int AREG_W = $clog2(ARCHREG_NUMBER),
    localparam int TAG_W  = $clog2(PREG_NUMBER)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [RETIRE_WIDTH-1:0]                    retire_valid_i,
    input  logic [RETIRE_WIDTH-1:0]                    retire_has_dest_i,
    input  logic [RETIRE_WIDTH-1:0][AREG_W-1:0]        retire_arch_reg_i,
    input  logic [RETIRE_WIDTH-1:0][TAG_W-1:0]         retire_new_tag_i,
    output logic                                       retire_ready_o,
    input  logic                                       branch_recover_i,
    output logic [ARCHREG_NUMBER-1:0][TAG_W-1:0]       arch_table_o,
    output logic [RETIRE_WIDTH-1:0]                    free_valid_o,
    output logic [RETIRE_WIDTH-1:0][TAG_W-1:0]         free_tag_o,
    output logic                                       rebuild_start_o,
    output logic [REBUILD_WIDTH-1:0]                   rebuild_valid_o,
    output logic [REBUILD_WIDTH-1:0][TAG_W-1:0]        rebuild_tag_o,
    output logic                                       rebuild_done_o
`ifdef ARCH_MAP_DEBUG_EN
    ,
    output logic [ARCHREG_NUMBER-1:0][TAG_W-1:0]       arch_table_Debug,
    output logic                                       state_Debug,
    output logic [TAG_W-1:0]                           scan_count_Debug
`endif
);

    localparam logic IDLE    = 1'b0;
    localparam logic REBUILD = 1'b1;

    localparam logic [TAG_W-1:0] LAST_SCAN = TAG_W'(PREG_NUMBER - REBUILD_WIDTH);
    localparam logic [TAG_W-1:0] SCAN_STEP = TAG_W'(REBUILD_WIDTH);

    logic                                 state_q, state_d;
    logic [TAG_W-1:0]                     scan_q, scan_d;
    logic [ARCHREG_NUMBER-1:0][TAG_W-1:0] table_q, table_d;
    logic [RETIRE_WIDTH-1:0]              free_valid_q, free_valid_d;
    logic [RETIRE_WIDTH-1:0][TAG_W-1:0]   free_tag_q, free_tag_d;

    logic                                 in_rebuild;
    logic                                 recover_commit;
    logic [REBUILD_WIDTH-1:0][TAG_W-1:0]  lane_tag;
    logic [REBUILD_WIDTH-1:0]             lane_hit;

    assign in_rebuild     = (state_q == REBUILD);
    assign retire_ready_o = ~in_rebuild;
    assign recover_commit = branch_recover_i & retire_ready_o;

    // Slots are applied in program order on a working copy of the table, so a
    // younger slot that targets the same register as an older one frees the
    // older slot's new tag and its own tag is the one that sticks.
    always_comb begin
        table_d      = table_q;
        free_valid_d = '0;
        free_tag_d   = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (retire_valid_i[i] && retire_ready_o && retire_has_dest_i[i] &&
                (retire_arch_reg_i[i] != '0)) begin
                // Tags superseded in a recovery cycle are picked up by the scan.
                free_valid_d[i] = ~recover_commit;
                free_tag_d[i]   = table_d[retire_arch_reg_i[i]];
                table_d[retire_arch_reg_i[i]] = retire_new_tag_i[i];
            end
        end
    end

    assign arch_table_o = table_d;

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        case (state_q)
            IDLE: begin
                if (recover_commit) begin
                    state_d = REBUILD;
                    scan_d  = '0;
                end
            end
            REBUILD: begin
                if (scan_q == LAST_SCAN) begin
                    state_d = IDLE;
                    scan_d  = '0;
                end else begin
                    scan_d = scan_q + SCAN_STEP;
                end
            end
            default: begin
                state_d = IDLE;
                scan_d  = '0;
            end
        endcase
    end

    // The table is frozen during the scan (retire_ready_o is low), so the
    // registered copy is a stable reference for the membership test.
    always_comb begin
        lane_tag = '0;
        lane_hit = '0;
        for (int j = 0; j < REBUILD_WIDTH; j++) begin
            lane_tag[j] = scan_q + TAG_W'(j);
            for (int a = 0; a < ARCHREG_NUMBER; a++) begin
                if (table_q[a] == lane_tag[j]) begin
                    lane_hit[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rebuild_valid_o = '0;
        for (int j = 0; j < REBUILD_WIDTH; j++) begin
            rebuild_valid_o[j] = in_rebuild && !lane_hit[j] && (lane_tag[j] != '0);
        end
    end

    assign rebuild_tag_o   = lane_tag;
    assign rebuild_start_o = in_rebuild && (scan_q == '0);
    assign rebuild_done_o  = in_rebuild && (scan_q == LAST_SCAN);
    assign free_valid_o    = free_valid_q;
    assign free_tag_o      = free_tag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            scan_q       <= '0;
            free_valid_q <= '0;
            free_tag_q   <= '0;
            for (int j = 0; j < ARCHREG_NUMBER; j++) begin
                table_q[j] <= TAG_W'(j);
            end
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            free_valid_q <= free_valid_d;
            free_tag_q   <= free_tag_d;
            table_q      <= table_d;
        end
    end

`ifdef ARCH_MAP_DEBUG_EN
    assign arch_table_Debug = table_q;
    assign state_Debug      = state_q;
    assign scan_count_Debug = scan_q;
`endif

endmodule
